lfsr_seq_checker: RTL and testbench

LFSR_SEQ_CHECKER -- requirements
Module: lfsr_seq_checker

---
 rtl/lfsr_seq_checker.sv | 150 +++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_seq_checker.sv
// Locks onto an 8-bit Fibonacci LFSR byte stream and counts mispredictions while locked.
// Define LFSR_SEQ_CHECKER_SEG_EN to enable the registered 7-segment display of err_cnt.
module lfsr_seq_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       din_valid,
    input  logic [7:0] din,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [6:0] seg_hi,
    output logic [6:0] seg_lo
);

    typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED} state_t;

    localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_W = 4'(LOSS_CNT);

    state_t     state, state_nxt;
    logic [7:0] pred, pred_nxt;
    logic [3:0] match_cnt, match_nxt, match_inc;
    logic [3:0] miss_cnt, miss_nxt, miss_inc;
    logic       err_hit;
    logic [7:0] err_cnt_nxt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    endfunction

    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= SEARCH;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= err_hit;
            err_cnt   <= err_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        err_hit   = 1'b0;
        if (din_valid) begin
            case (state)
                SEARCH: begin
                    if (din != 8'h00) begin
                        pred_nxt  = lfsr_next(din);
                        match_nxt = '0;
                        state_nxt = CONFIRM;
                    end
                end
                CONFIRM: begin
                    if (din == pred) begin
                        pred_nxt  = lfsr_next(din);
                        match_nxt = match_inc;
                        if (match_inc == LOCK_W) state_nxt = LOCKED;
                    end else if (din != 8'h00) begin
                        pred_nxt  = lfsr_next(din);
                        match_nxt = '0;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
                LOCKED: begin
                    // Once locked the predictor follows its own sequence, never the input.
                    pred_nxt = lfsr_next(pred);
                    if (din == pred) begin
                        miss_nxt = '0;
                    end else begin
                        err_hit = 1'b1;
                        if (miss_inc == LOSS_W) begin
                            miss_nxt  = '0;
                            state_nxt = SEARCH;
                        end else begin
                            miss_nxt = miss_inc;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (clr_err)
            err_cnt_nxt = '0;
        else if (err_hit && err_cnt != 8'hFF)
            err_cnt_nxt = err_cnt + 8'd1;
    end

`ifdef LFSR_SEQ_CHECKER_SEG_EN
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Decoded from the next count so the display lines up with err_cnt.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            seg_hi <= 7'b1000000;
            seg_lo <= 7'b1000000;
        end else begin
            seg_hi <= hex7(err_cnt_nxt[7:4]);
            seg_lo <= hex7(err_cnt_nxt[3:0]);
        end
    end
`else
    assign seg_hi = '1;
    assign seg_lo = '1;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: vector table plus hand sequences through a scoreboard queue.
// Segment expectations follow LFSR_SEQ_CHECKER_SEG_EN as seen by this compile.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       clrn;
    logic       din_valid;
    logic [7:0] din;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [6:0] seg_hi;
    logic [6:0] seg_lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       el;
        logic       ep;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .din_valid (din_valid),
        .din       (din),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .seg_hi    (seg_hi),
        .seg_lo    (seg_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    function automatic logic [7:0] lf(input logic [7:0] x);
        return {x[4] ^ x[3] ^ x[2] ^ x[0], x[7:1]};
    endfunction

    function automatic logic [6:0] seg_exp(input logic [3:0] v);
`ifdef LFSR_SEQ_CHECKER_SEG_EN
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
`else
        return (v == 4'h0) ? 7'h7F : 7'h7F;
`endif
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic el, input logic ep, input logic [7:0] ec);
        chk({tag, " locked"},    {7'd0, locked},    {7'd0, el});
        chk({tag, " err_pulse"}, {7'd0, err_pulse}, {7'd0, ep});
        chk({tag, " err_cnt"},   err_cnt,           ec);
        chk({tag, " seg_hi"},    {1'b0, seg_hi},    {1'b0, seg_exp(ec[7:4])});
        chk({tag, " seg_lo"},    {1'b0, seg_lo},    {1'b0, seg_exp(ec[3:0])});
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c,
                        input logic el, input logic ep, input logic [7:0] ec);
        vec_t r;
        din_valid = v;
        din       = d;
        clr_err   = c;
        exp_q.push_back('{v, d, c, el, ep, ec});
        @(posedge clk);
        #1;
        r = exp_q.pop_front();
        chk_out(tag, r.el, r.ep, r.ec);
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic c,
                       input logic el, input logic ep, input logic [7:0] ec);
        tbl.push_back('{v, d, c, el, ep, ec});
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] p;
        int         e;
        int         n;

        // Lock on 01,80,40,20,10; predictor is then 0x88.
        x = 8'h01;
        add(1, x, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            x = lf(x);
            add(1, x, 0, (k == 4), 0, 8'd0);
        end
        p = lf(x);
        add(0, 8'h55, 0, 1, 0, 8'd0);
        add(1, 8'h00, 0, 1, 1, 8'd1);
        p = lf(p);
        add(1, p, 0, 1, 0, 8'd1);
        add(1, 8'hAA, 0, 1, 1, 8'd2);
        add(1, 8'hAA, 0, 1, 1, 8'd3);
        add(1, 8'hAA, 0, 0, 1, 8'd4);
        add(1, 8'h00, 0, 0, 0, 8'd4);
        add(1, 8'h00, 0, 0, 0, 8'd4);
        // Reseed inside CONFIRM, with an idle cycle that must not disturb it.
        add(1, 8'h01, 0, 0, 0, 8'd4);
        add(1, 8'h80, 0, 0, 0, 8'd4);
        add(1, 8'h33, 0, 0, 0, 8'd4);
        add(0, 8'hFF, 0, 0, 0, 8'd4);
        x = 8'h33;
        for (int k = 1; k <= 4; k++) begin
            x = lf(x);
            add(1, x, 0, (k == 4), 0, 8'd4);
        end
        p = lf(x);
        add(1, 8'h00, 1, 1, 1, 8'd0);
        p = lf(p);
        add(1, p, 0, 1, 0, 8'd0);

        clrn = 1'b0; din_valid = 1'b0; din = 8'h00; clr_err = 1'b0;
        #1;
        chk_out("por", 0, 0, 8'd0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].c,
                              tbl[i].el, tbl[i].ep, tbl[i].ec);

        // Drop lock, then 0x00 in CONFIRM must fall back to SEARCH so 0x80 reseeds.
        step("loss1", 1, 8'h00, 0, 1, 1, 8'd1);
        step("loss2", 1, 8'h00, 0, 1, 1, 8'd2);
        step("loss3", 1, 8'h00, 0, 0, 1, 8'd3);
        step("cf_seed", 1, 8'h01, 0, 0, 0, 8'd3);
        step("cf_zero", 1, 8'h00, 0, 0, 0, 8'd3);
        x = 8'h80;
        step("cf_re0", 1, x, 0, 0, 0, 8'd3);
        for (int k = 1; k <= 4; k++) begin
            x = lf(x);
            step($sformatf("cf_re%0d", k), 1, x, 0, (k == 4), 0, 8'd3);
        end

        // Saturation: 258 mismatches across repeated loss/relock cycles.
        e = 3;
        n = 0;
        while (n < 258) begin
            for (int j = 0; j < 3; j++) begin
                e = (e < 255) ? e + 1 : 255;
                step("sat_miss", 1, 8'h00, 0, (j < 2), 1, 8'(e));
                n++;
            end
            x = 8'h01;
            step("sat_lock", 1, x, 0, 0, 0, 8'(e));
            for (int k = 1; k <= 4; k++) begin
                x = lf(x);
                step("sat_lock", 1, x, 0, (k == 4), 0, 8'(e));
            end
        end
        chk("sat_final", err_cnt, 8'hFF);
        step("sat_clr", 1, 8'h00, 1, 1, 1, 8'd0);
        step("post_clr", 1, 8'h00, 0, 1, 1, 8'd1);

        // Asynchronous reset while locked with pending error state.
        din_valid = 1'b1;
        din = 8'hAA;
        #2;
        clrn = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 8'd0);
        repeat (4) @(negedge clk) din_valid = ~din_valid;
        @(posedge clk);
        #1;
        chk_out("rst_held", 0, 0, 8'd0);
        @(negedge clk);
        clrn = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        x = 8'h88;
        step("fresh0", 1, x, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 4; k++) begin
            x = lf(x);
            step($sformatf("fresh%0d", k), 1, x, 0, (k == 4), 0, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
